// File: rtl/conv_pkg.sv
// Shared constants, state encoding and flat-bus slice helper for the conv PE loader.
package conv_pkg;

  localparam int DATA_W = 8;
  localparam int N_W    = 9;
  localparam int N_IN   = 16;
  localparam int IDX_W  = $clog2(N_IN);

  typedef enum logic [2:0] {
    LOAD_W  = 3'd0,
    LOAD_IN = 3'd1,
    WLOAD   = 3'd2,
    START   = 3'd3,
    WAIT    = 3'd4
  } state_t;

  // Low bit of a byte slot inside a row-major flat bus.
  function automatic int slot_lo(input int slot);
    return slot * DATA_W;
  endfunction

endpackage

// File: rtl/conv_loader.sv
// Serial byte stream -> 9 weights + 16 map bytes; weight_load/start 1 and 2 cycles after the last byte.
// s_ready drops from WLOAD until conv_done; optional CONV_LOADER_WEIGHT_REUSE_EN adds keep_w.
module conv_loader
  import conv_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [N_W*DATA_W-1:0]    w_flat,
  output logic [N_IN*DATA_W-1:0]   in_flat,
  output logic                     weight_load,
  output logic                     start,
  input  logic                     conv_done,
`ifdef CONV_LOADER_WEIGHT_REUSE_EN
  input  logic                     keep_w,
`endif
  output logic                     busy
);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [IDX_W-1:0]         r_idx;
  logic [IDX_W-1:0]         w_idx_nxt;
  logic [N_W*DATA_W-1:0]    r_w_flat;
  logic [N_IN*DATA_W-1:0]   r_in_flat;
  logic                     w_acc;
  logic                     w_hold;
  logic                     w_skip_w;

`ifdef CONV_LOADER_WEIGHT_REUSE_EN
  logic r_fresh;
  logic r_skip_w;
  logic w_skip_nxt;

  // First cycle after reset counts as entering LOAD_W; hold the stream while redirecting.
  assign w_hold   = r_fresh && keep_w && (r_state == LOAD_W);
  assign w_skip_w = r_skip_w;
`else
  assign w_hold   = 1'b0;
  assign w_skip_w = 1'b0;
`endif

  assign s_ready = ((r_state == LOAD_W) || (r_state == LOAD_IN)) && !flush && !w_hold;
  assign w_acc   = s_valid && s_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      LOAD_W: begin
        if (w_acc) begin
          if (r_idx == IDX_W'(N_W - 1)) begin
            w_idx_nxt   = '0;
            w_state_nxt = LOAD_IN;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      LOAD_IN: begin
        if (w_acc) begin
          if (r_idx == IDX_W'(N_IN - 1)) begin
            w_idx_nxt   = '0;
            w_state_nxt = w_skip_w ? START : WLOAD;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      WLOAD: w_state_nxt = START;
      START: w_state_nxt = WAIT;
      WAIT: begin
        if (conv_done) begin
          w_state_nxt = LOAD_W;
          w_idx_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = LOAD_W;
        w_idx_nxt   = '0;
      end
    endcase
    if (flush) begin
      w_state_nxt = LOAD_W;
      w_idx_nxt   = '0;
    end
`ifdef CONV_LOADER_WEIGHT_REUSE_EN
    w_skip_nxt = r_skip_w;
    if (keep_w && (w_state_nxt == LOAD_W) && ((r_state != LOAD_W) || flush || r_fresh)) begin
      w_state_nxt = LOAD_IN;
      w_skip_nxt  = 1'b1;
    end else if (w_state_nxt == LOAD_W) begin
      w_skip_nxt = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= LOAD_W;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

`ifdef CONV_LOADER_WEIGHT_REUSE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fresh  <= 1'b1;
      r_skip_w <= 1'b0;
    end else begin
      r_fresh  <= 1'b0;
      r_skip_w <= w_skip_nxt;
    end
  end
`endif

  // Byte-enable writes: one slot per accepted byte, selected by state and idx.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_w_flat  <= '0;
      r_in_flat <= '0;
    end else if (w_acc) begin
      for (int i = 0; i < N_W; i++) begin
        if ((r_state == LOAD_W) && (r_idx == IDX_W'(i)))
          r_w_flat[slot_lo(i) +: DATA_W] <= s_data;
      end
      for (int i = 0; i < N_IN; i++) begin
        if ((r_state == LOAD_IN) && (r_idx == IDX_W'(i)))
          r_in_flat[slot_lo(i) +: DATA_W] <= s_data;
      end
    end
  end

  assign w_flat      = r_w_flat;
  assign in_flat     = r_in_flat;
  assign weight_load = (r_state == WLOAD) && !flush;
  assign start       = (r_state == START) && !flush;
  assign busy        = (r_state == WLOAD) || (r_state == START) || (r_state == WAIT);

endmodule

// File: tb/tb_conv_loader.sv
// Bench for conv_loader: randomized frames against a byte-array reference model of the loader.
module tb_conv_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic [7:0]   s_data = 8'h00;
  logic         s_valid = 1'b0;
  logic         conv_done = 1'b0;
  logic         s_ready;
  logic [71:0]  w_flat;
  logic [127:0] in_flat;
  logic         weight_load;
  logic         start;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bytes seen so far, position in frame, phase after loading.
  logic [7:0] m_w [9];
  logic [7:0] m_in[16];
  int         m_cnt;
  int         m_ph;   // 0 loading, 1 weight_load cycle, 2 start cycle, 3 waiting for done

  conv_loader dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .w_flat      (w_flat),
    .in_flat     (in_flat),
    .weight_load (weight_load),
    .start       (start),
    .conv_done   (conv_done),
`ifdef CONV_LOADER_WEIGHT_REUSE_EN
    .keep_w      (1'b0),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 9; i++)  m_w[i]  = 8'h00;
    for (int i = 0; i < 16; i++) m_in[i] = 8'h00;
    m_cnt = 0;
    m_ph  = 0;
  endtask

  // Applies what the coming rising edge does with the inputs currently driven.
  task automatic model_commit();
    if (flush) begin
      m_cnt = 0;
      m_ph  = 0;
    end else begin
      case (m_ph)
        0: if (s_valid) begin
             if (m_cnt < 9) m_w[m_cnt] = s_data;
             else           m_in[m_cnt - 9] = s_data;
             m_cnt++;
             if (m_cnt == 25) begin
               m_cnt = 0;
               m_ph  = 1;
             end
           end
        1: m_ph = 2;
        2: m_ph = 3;
        default: if (conv_done) m_ph = 0;
      endcase
    end
  endtask

  function automatic logic [3:0] exp_ctl();
    return {(m_ph == 0) && !flush, (m_ph == 1) && !flush, (m_ph == 2) && !flush, m_ph != 0};
  endfunction

  function automatic logic [199:0] exp_flat();
    logic [199:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = m_in[i];
    for (int i = 0; i < 9; i++)  r[128 + i*8 +: 8] = m_w[i];
    return r;
  endfunction

  task automatic apply(input logic v, input logic [7:0] d, input logic f, input logic dn);
    @(negedge clk);
    s_valid   = v;
    s_data    = d;
    flush     = f;
    conv_done = dn;
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if ({w_flat, in_flat} !== 200'd0) begin
      n_fail++;
      $display("FAIL reset_flat got=%h exp=0", {w_flat, in_flat});
    end
    n_tests++;
    if ({weight_load, start, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctl got=%b exp=000", {weight_load, start, busy});
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got=%b exp=1", s_ready);
    end
  endtask

  task automatic test_back_to_back();
    int wl_cyc = -1;
    int st_cyc = -1;
    for (int c = 1; c <= 27; c++) begin
      apply(1'b1, 8'(c), 1'b0, 1'b0);
      n_tests++;
      if ({s_ready, weight_load, start, busy} !== exp_ctl()) begin
        n_fail++;
        $display("FAIL b2b_ctl cyc=%0d got=%b exp=%b", c, {s_ready, weight_load, start, busy}, exp_ctl());
      end
      n_tests++;
      if ({w_flat, in_flat} !== exp_flat()) begin
        n_fail++;
        $display("FAIL b2b_flat cyc=%0d got=%h exp=%h", c, {w_flat, in_flat}, exp_flat());
      end
      if (weight_load === 1'b1 && wl_cyc < 0) wl_cyc = c;
      if (start === 1'b1 && st_cyc < 0) st_cyc = c;
      model_commit();
    end
    n_tests++;
    if (wl_cyc != 26) begin
      n_fail++;
      $display("FAIL b2b_wl_cycle got=%0d exp=26", wl_cyc);
    end
    n_tests++;
    if (st_cyc != 27) begin
      n_fail++;
      $display("FAIL b2b_start_cycle got=%0d exp=27", st_cyc);
    end
    n_tests++;
    if ({w_flat[71:64], w_flat[7:0], in_flat[127:120], in_flat[7:0]} !== {8'd9, 8'd1, 8'd25, 8'd10}) begin
      n_fail++;
      $display("FAIL b2b_corners got=%h exp=0901190a",
               {w_flat[71:64], w_flat[7:0], in_flat[127:120], in_flat[7:0]});
    end
  endtask

  task automatic test_wait_hold();
    for (int c = 0; c < 40; c++) begin
      // 10 idle WAIT cycles, then conv_done, then a full random frame up to WAIT again
      apply(1'b1, 8'($urandom), 1'b0, c == 10);
      n_tests++;
      if ({s_ready, weight_load, start, busy} !== exp_ctl()) begin
        n_fail++;
        $display("FAIL wait_ctl cyc=%0d got=%b exp=%b", c, {s_ready, weight_load, start, busy}, exp_ctl());
      end
      n_tests++;
      if ({w_flat, in_flat} !== exp_flat()) begin
        n_fail++;
        $display("FAIL wait_flat cyc=%0d got=%h exp=%h", c, {w_flat, in_flat}, exp_flat());
      end
      model_commit();
    end
    apply(1'b0, 8'h00, 1'b0, 1'b1);
    model_commit();
  endtask

  task automatic test_gappy();
    logic [71:0]  e_w;
    logic [127:0] e_in;
    for (int c = 1; c <= 52; c++) begin
      logic v;
      v = (c % 2 == 1) && (c <= 49);
      apply(v, v ? 8'((c + 1) / 2) : 8'hEE, 1'b0, 1'b0);
      n_tests++;
      if ({s_ready, weight_load, start, busy} !== exp_ctl()) begin
        n_fail++;
        $display("FAIL gap_ctl cyc=%0d got=%b exp=%b", c, {s_ready, weight_load, start, busy}, exp_ctl());
      end
      model_commit();
    end
    for (int i = 0; i < 9; i++)  e_w[i*8 +: 8]  = 8'(i + 1);
    for (int i = 0; i < 16; i++) e_in[i*8 +: 8] = 8'(i + 10);
    n_tests++;
    if ({w_flat, in_flat} !== {e_w, e_in}) begin
      n_fail++;
      $display("FAIL gap_flat got=%h exp=%h", {w_flat, in_flat}, {e_w, e_in});
    end
    apply(1'b0, 8'h00, 1'b0, 1'b1);
    model_commit();
  endtask

  task automatic test_flush();
    int n_wl = 0;
    int n_st = 0;
    for (int c = 0; c < 41; c++) begin
      if (c < 12)       apply(1'b1, 8'($urandom), 1'b0, 1'b0);
      else if (c == 12) apply(1'b1, 8'h55, 1'b1, 1'b0);
      else              apply(1'b1, (c < 38) ? 8'(8'hA0 + c - 13) : 8'h00, 1'b0, 1'b0);
      n_tests++;
      if ({s_ready, weight_load, start, busy} !== exp_ctl()) begin
        n_fail++;
        $display("FAIL flush_ctl cyc=%0d got=%b exp=%b", c, {s_ready, weight_load, start, busy}, exp_ctl());
      end
      n_tests++;
      if ({w_flat, in_flat} !== exp_flat()) begin
        n_fail++;
        $display("FAIL flush_flat cyc=%0d got=%h exp=%h", c, {w_flat, in_flat}, exp_flat());
      end
      if (weight_load === 1'b1) n_wl++;
      if (start === 1'b1) n_st++;
      model_commit();
    end
    n_tests++;
    if (n_wl != 1 || n_st != 1) begin
      n_fail++;
      $display("FAIL flush_pulses got=%0d/%0d exp=1/1", n_wl, n_st);
    end
    n_tests++;
    if ({w_flat[7:0], in_flat[127:120]} !== 16'hA0B8) begin
      n_fail++;
      $display("FAIL flush_first_last got=%h exp=a0b8", {w_flat[7:0], in_flat[127:120]});
    end
    apply(1'b0, 8'h00, 1'b0, 1'b1);
    model_commit();
  endtask

  task automatic test_async_reset();
    logic [7:0] first;
    for (int c = 0; c < 15; c++) begin
      apply(1'b1, 8'($urandom), 1'b0, 1'b0);
      model_commit();
    end
    @(posedge clk);
    #2;
    s_valid = 1'b0;
    rst     = 1'b0;
    #1;
    n_tests++;
    if ({w_flat, in_flat} !== 200'd0) begin
      n_fail++;
      $display("FAIL arst_flat got=%h exp=0", {w_flat, in_flat});
    end
    n_tests++;
    if ({weight_load, start, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL arst_ctl got=%b exp=000", {weight_load, start, busy});
    end
    model_reset();
    @(negedge clk);
    rst   = 1'b1;
    first = 8'($urandom);
    for (int c = 0; c < 28; c++) begin
      apply(1'b1, (c == 0) ? first : 8'($urandom), 1'b0, 1'b0);
      n_tests++;
      if ({s_ready, weight_load, start, busy} !== exp_ctl()) begin
        n_fail++;
        $display("FAIL arst_ctl2 cyc=%0d got=%b exp=%b", c, {s_ready, weight_load, start, busy}, exp_ctl());
      end
      model_commit();
    end
    n_tests++;
    if ({w_flat, in_flat} !== exp_flat() || w_flat[7:0] !== first) begin
      n_fail++;
      $display("FAIL arst_reload got=%h exp=%h", {w_flat, in_flat}, exp_flat());
    end
    apply(1'b0, 8'h00, 1'b0, 1'b1);
    model_commit();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      apply($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 63) == 0,
            $urandom_range(0, 7) == 0);
      n_tests++;
      if ({s_ready, weight_load, start, busy} !== exp_ctl()) begin
        n_fail++;
        $display("FAIL rand_ctl cyc=%0d got=%b exp=%b", c, {s_ready, weight_load, start, busy}, exp_ctl());
      end
      n_tests++;
      if ({w_flat, in_flat} !== exp_flat()) begin
        n_fail++;
        $display("FAIL rand_flat cyc=%0d got=%h exp=%h", c, {w_flat, in_flat}, exp_flat());
      end
      model_commit();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wait_hold();
    test_gappy();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
